// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback, one state per cycle.
// Latency: 3-5 cycles per instruction (2 for an illegal opcode); no backpressure, flag is used combinationally in BRANCH.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             flag,
  output logic [3:0]       AluOP,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic [1:0]       PCSrc,
  output logic             PCEn,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b1010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;

  state_t     state, nextState;
  logic [3:0] functOp;
  logic       functOk;
  logic       illegalNext;
  logic       retire;

  always_comb begin
    functOp = ALU_ADD;
    functOk = 1'b1;
    case (funct)
      6'b100000: functOp = ALU_ADD;
      6'b100010: functOp = ALU_SUB;
      6'b100100: functOp = ALU_AND;
      6'b100101: functOp = ALU_OR;
      6'b100110: functOp = ALU_XOR;
      6'b100111: functOp = ALU_NOR;
      6'b101010: functOp = ALU_SLT;
      default:   functOk = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= nextState;
  end

  always_comb begin
    nextState   = FETCH;
    illegalNext = 1'b0;
    retire      = 1'b0;
    AluOP       = ALU_ADD;
    AluSrcA     = 1'b0;
    AluSrcB     = 2'b00;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    PCSrc       = 2'b00;
    PCEn        = 1'b0;
    // Everything stays quiet while reset is held, even though the state reads FETCH.
    if (rst_n) begin
      case (state)
        FETCH: begin
          AluSrcB   = 2'b01;
          IRWrite   = 1'b1;
          PCEn      = 1'b1;
          nextState = DECODE;
        end
        DECODE: begin
          AluSrcB = 2'b11;
          case (opcode)
            OP_LW, OP_SW: nextState = MEMADR;
            OP_RTYPE:     nextState = EXEC;
            OP_BEQ:       nextState = BRANCH;
            OP_ADDI:      nextState = ADDIEX;
            OP_J:         nextState = JUMP;
            default:      illegalNext = 1'b1;
          endcase
        end
        MEMADR: begin
          AluSrcA   = 1'b1;
          AluSrcB   = 2'b10;
          nextState = (opcode == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          IorD      = 1'b1;
          nextState = MEMWB;
        end
        MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
          retire   = 1'b1;
        end
        EXEC: begin
          AluSrcA = 1'b1;
          AluOP   = functOp;
          if (functOk) nextState = ALUWB;
          else         illegalNext = 1'b1;
        end
        ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        BRANCH: begin
          AluSrcA = 1'b1;
          AluOP   = ALU_SUB;
          PCSrc   = 2'b01;
          PCEn    = (flag === 1'b1);
          retire  = 1'b1;
        end
        ADDIEX: begin
          AluSrcA   = 1'b1;
          AluSrcB   = 2'b10;
          nextState = ADDIWB;
        end
        ADDIWB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        JUMP: begin
          PCSrc  = 2'b10;
          PCEn   = 1'b1;
          retire = 1'b1;
        end
        default: nextState = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      illegal <= illegalNext;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class cycle by cycle against hand-written state outputs.
// Counter is built 3 bits wide so the wrap from 7 to 0 is reached with a short program.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       flag;
  logic [3:0] AluOP;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic       IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic       illegal;
  logic [2:0] instr_count;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .flag(flag),
    .AluOP(AluOP), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .IorD(IorD),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .PCSrc(PCSrc), .PCEn(PCEn), .illegal(illegal),
    .instr_count(instr_count)
  );

  logic [16:0] outs;
  assign outs = {AluOP, AluSrcA, AluSrcB, IorD, MemWrite, IRWrite, RegWrite,
                 RegDst, MemtoReg, PCSrc, PCEn, illegal};

  function automatic logic [16:0] ev(input logic [3:0] op, input logic a, input logic [1:0] b,
                                     input logic iord, input logic mw, input logic irw,
                                     input logic rw, input logic rd, input logic m2r,
                                     input logic [1:0] pcs, input logic pce, input logic ill);
    return {op, a, b, iord, mw, irw, rw, rd, m2r, pcs, pce, ill};
  endfunction

  localparam logic [16:0] S_FETCH   = ev(4'b0000, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0);
  localparam logic [16:0] S_FETCHIL = ev(4'b0000, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00, 1, 1);
  localparam logic [16:0] S_DECODE  = ev(4'b0000, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  localparam logic [16:0] S_MEMADR  = ev(4'b0000, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  localparam logic [16:0] S_MEMRD   = ev(4'b0000, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  localparam logic [16:0] S_MEMWB   = ev(4'b0000, 0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0);
  localparam logic [16:0] S_MEMWR   = ev(4'b0000, 0, 2'b00, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0);
  localparam logic [16:0] S_ALUWB   = ev(4'b0000, 0, 2'b00, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0);
  localparam logic [16:0] S_BR_TAKE = ev(4'b0010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0);
  localparam logic [16:0] S_BR_NOT  = ev(4'b0010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
  localparam logic [16:0] S_ADDIEX  = ev(4'b0000, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  localparam logic [16:0] S_ADDIWB  = ev(4'b0000, 0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0);
  localparam logic [16:0] S_JUMP    = ev(4'b0000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0);
  localparam logic [16:0] S_EXSLT   = ev(4'b1010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  localparam logic [16:0] S_EXXOR   = ev(4'b0110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  localparam logic [16:0] S_EXSUB   = ev(4'b0010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle's outputs, then advance to 2ns after the next rising edge.
  task automatic stepChk(input string tag, input logic [16:0] exp);
    chk(tag, {15'b0, outs}, {15'b0, exp});
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b000000;
    funct  = 6'b101010;
    flag   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_enables", {28'b0, PCEn, IRWrite, MemWrite, RegWrite}, 32'd0);
    chk("rst_aluop", {28'b0, AluOP}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_count", {29'b0, instr_count}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // R-type slt
    stepChk("slt_fetch", S_FETCH);
    stepChk("slt_decode", S_DECODE);
    stepChk("slt_exec", S_EXSLT);
    stepChk("slt_aluwb", S_ALUWB);
    chk("slt_count", {29'b0, instr_count}, 32'd1);

    opcode = 6'b100011;
    stepChk("lw_fetch", S_FETCH);
    stepChk("lw_decode", S_DECODE);
    stepChk("lw_memadr", S_MEMADR);
    stepChk("lw_memrd", S_MEMRD);
    stepChk("lw_memwb", S_MEMWB);
    chk("lw_count", {29'b0, instr_count}, 32'd2);

    opcode = 6'b101011;
    stepChk("sw_fetch", S_FETCH);
    stepChk("sw_decode", S_DECODE);
    stepChk("sw_memadr", S_MEMADR);
    stepChk("sw_memwr", S_MEMWR);
    chk("sw_count", {29'b0, instr_count}, 32'd3);

    opcode = 6'b000100;
    flag   = 1'b1;
    stepChk("beq1_fetch", S_FETCH);
    stepChk("beq1_decode", S_DECODE);
    stepChk("beq1_branch", S_BR_TAKE);
    chk("beq1_count", {29'b0, instr_count}, 32'd4);

    flag = 1'b0;
    stepChk("beq0_fetch", S_FETCH);
    stepChk("beq0_decode", S_DECODE);
    stepChk("beq0_branch", S_BR_NOT);
    chk("beq0_count", {29'b0, instr_count}, 32'd5);

    opcode = 6'b111111;
    stepChk("illop_fetch", S_FETCH);
    stepChk("illop_decode", S_DECODE);
    chk("illop_count", {29'b0, instr_count}, 32'd5);

    opcode = 6'b000000;
    funct  = 6'b000001;
    stepChk("illop_pulse", S_FETCHIL);
    stepChk("illfn_decode", S_DECODE);
    chk("illfn_exec_wr", {29'b0, AluSrcA, RegWrite, MemWrite}, 32'b100);
    @(posedge clk);
    #2;
    funct = 6'b100110;
    stepChk("illfn_pulse", S_FETCHIL);
    chk("illfn_count", {29'b0, instr_count}, 32'd5);
    stepChk("xor_decode", S_DECODE);
    stepChk("xor_exec", S_EXXOR);
    stepChk("xor_aluwb", S_ALUWB);
    chk("xor_count", {29'b0, instr_count}, 32'd6);

    opcode = 6'b001000;
    stepChk("addi_fetch", S_FETCH);
    stepChk("addi_decode", S_DECODE);
    stepChk("addi_ex", S_ADDIEX);
    stepChk("addi_wb", S_ADDIWB);
    chk("addi_count", {29'b0, instr_count}, 32'd7);

    opcode = 6'b000010;
    stepChk("j_fetch", S_FETCH);
    stepChk("j_decode", S_DECODE);
    stepChk("j_jump", S_JUMP);
    chk("j_count_wrap", {29'b0, instr_count}, 32'd0);

    opcode = 6'b000000;
    funct  = 6'b100010;
    stepChk("sub_fetch", S_FETCH);
    stepChk("sub_decode", S_DECODE);
    stepChk("sub_exec", S_EXSUB);
    stepChk("sub_aluwb", S_ALUWB);
    chk("sub_count", {29'b0, instr_count}, 32'd1);

    // lw abandoned by reset while in MEMRD
    opcode = 6'b100011;
    stepChk("lwrst_fetch", S_FETCH);
    stepChk("lwrst_decode", S_DECODE);
    stepChk("lwrst_memadr", S_MEMADR);
    chk("lwrst_memrd", {15'b0, outs}, {15'b0, S_MEMRD});
    #1;
    rst_n = 1'b0;
    #2;
    chk("lwrst_enables", {28'b0, PCEn, IRWrite, MemWrite, RegWrite}, 32'd0);
    chk("lwrst_count", {29'b0, instr_count}, 32'd0);
    @(posedge clk);
    #2;
    chk("lwrst_hold_regwr", {31'b0, RegWrite}, 32'd0);
    @(negedge clk);
    opcode = 6'b000010;
    rst_n  = 1'b1;
    #1;
    stepChk("post_fetch", S_FETCH);
    stepChk("post_decode", S_DECODE);
    stepChk("post_jump", S_JUMP);
    chk("post_count", {29'b0, instr_count}, 32'd1);
    chk("post_fetch2", {15'b0, outs}, {15'b0, S_FETCH});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
